// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU:
// opcodes, flag bit positions and FSM states.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_EOR = 4'd4,
    OP_BIC = 4'd5,
    OP_RSB = 4'd6,
    OP_CMP = 4'd7,
    OP_MUL = 4'd8,
    OP_LSL = 4'd9,
    OP_LSR = 4'd10
  } op_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier, one multiplier bit per cycle;
// bit 0 is folded into the start cycle.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign done = busy_q && (cnt_q == CW'(WIDTH));
  assign prod = prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      prod_q   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_q <= b >> 1;
      cnt_q    <= CW'(1);
      busy_q   <= 1'b1;
    end else if (done) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0])
        prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops,
// multi-cycle shift-add MUL, valid/ready on both sides.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             equal,
  output logic             err
);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             equal_q;
  logic             err_q;

  logic               accept;
  logic               mul_sel;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dab;
  logic [WIDTH:0]   dba;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic             sh_zero;
  logic             sh_big;
  logic             legal;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flg;
  logic             alu_c;
  logic             alu_v;

  // HOLD releases its result in the same cycle out_ready
  // rises, so a new request may be taken in that cycle.
  assign in_ready = rst_n && (state_q != ST_MUL)
                    && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_sel  = MUL_EN && (op == OP_MUL);

  assign sum = {1'b0, a} + {1'b0, b};
  assign dab = {1'b0, a} - {1'b0, b};
  assign dba = {1'b0, b} - {1'b0, a};
  assign shl = {1'b0, a} << b;
  assign shr = {a, 1'b0} >> b;

  assign sh_zero = (b == '0);
  assign sh_big  = (b >= WIDTH'(WIDTH));
  assign legal   = (op <= OP_LSR) && (MUL_EN || op != OP_MUL);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1])
                  && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = dab[WIDTH-1:0];
        alu_c   = ~dab[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1])
                  && (dab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_RSB: begin
        alu_res = dba[WIDTH-1:0];
        alu_c   = ~dba[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1])
                  && (dba[WIDTH-1] != b[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_EOR: alu_res = a ^ b;
      OP_BIC: alu_res = a & ~b;
      OP_LSL: begin
        if (sh_zero) begin
          alu_res = a;
        end else if (!sh_big) begin
          alu_res = shl[WIDTH-1:0];
          alu_c   = shl[WIDTH];
        end
      end
      OP_LSR: begin
        if (sh_zero) begin
          alu_res = a;
        end else if (!sh_big) begin
          alu_res = shr[WIDTH:1];
          alu_c   = shr[0];
        end
      end
      default: ;
    endcase
    alu_flg        = '0;
    alu_flg[FLG_N] = alu_res[WIDTH-1];
    alu_flg[FLG_Z] = (alu_res == '0);
    alu_flg[FLG_C] = alu_c;
    alu_flg[FLG_V] = alu_v;
    if (!legal) begin
      alu_res = '0;
      alu_flg = '0;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && mul_sel),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      equal_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (state_q == ST_HOLD && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            equal_q <= (a == b);
            if (mul_sel) begin
              state_q     <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              flags_q     <= alu_flg;
              err_q       <= ~legal;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q        <= ST_HOLD;
            out_valid_q    <= 1'b1;
            result_q       <= mul_prod[WIDTH-1:0];
            flags_q        <= '0;
            flags_q[FLG_N] <= mul_prod[WIDTH-1];
            flags_q[FLG_Z] <= (mul_prod[WIDTH-1:0] == '0);
            flags_q[FLG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
            err_q          <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign equal     = equal_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic [3:0]  flg8;
  logic        eq8, err8;

  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
  logic [3:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  flg16;
  logic        eq16, err16;

  seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .flags(flg8),
    .equal(eq8), .err(err8)
  );

  seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(ordy16),
    .result(res16), .flags(flg16),
    .equal(eq16), .err(err16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run8(input logic [3:0] o,
                      input logic [7:0] x, y,
                      output int lat);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run16(input logic [3:0] o,
                       input logic [15:0] x, y,
                       output int lat);
    @(negedge clk);
    op16 = o; a16 = x; b16 = y; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    logic       eq;
    logic       er;
    int         lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int lat;
    int seen;
    tbl = '{
      '{OP_ADD, 8'd200, 8'd100, 8'd44,  4'b0010, 1'b0, 1'b0, 1},
      '{OP_SUB, 8'd5,   8'd7,   8'd254, 4'b1000, 1'b0, 1'b0, 1},
      '{OP_ADD, 8'd100, 8'd100, 8'd200, 4'b1001, 1'b1, 1'b0, 1},
      '{OP_CMP, 8'd9,   8'd9,   8'd0,   4'b0110, 1'b1, 1'b0, 1},
      '{OP_MUL, 8'd13,  8'd11,  8'd143, 4'b1000, 1'b0, 1'b0, 9},
      '{OP_MUL, 8'd16,  8'd16,  8'd0,   4'b0110, 1'b1, 1'b0, 9},
      '{4'd15,  8'd3,   8'd3,   8'd0,   4'b0000, 1'b1, 1'b1, 1},
      '{OP_LSL, 8'h81,  8'd1,   8'h02,  4'b0010, 1'b0, 1'b0, 1},
      '{OP_LSR, 8'hA5,  8'd8,   8'h00,  4'b0100, 1'b0, 1'b0, 1},
      '{OP_RSB, 8'd3,   8'd10,  8'd7,   4'b0010, 1'b0, 1'b0, 1},
      '{OP_BIC, 8'hF0,  8'h30,  8'hC0,  4'b1000, 1'b0, 1'b0, 1},
      '{OP_EOR, 8'hFF,  8'h0F,  8'hF0,  4'b1000, 1'b0, 1'b0, 1},
      '{OP_LSR, 8'h81,  8'd1,   8'h40,  4'b0010, 1'b0, 1'b0, 1},
      '{OP_AND, 8'h3C,  8'h0F,  8'h0C,  4'b0000, 1'b0, 1'b0, 1},
      '{OP_LSL, 8'h5A,  8'd0,   8'h5A,  4'b0000, 1'b0, 1'b0, 1}
    };

    repeat (2) @(negedge clk);
    chk("rst.ir8",  32'(ir8),  32'd0);
    chk("rst.ov8",  32'(ov8),  32'd0);
    chk("rst.res8", 32'(res8), 32'd0);
    chk("rst.flg8", 32'(flg8), 32'd0);
    chk("rst.eq8",  32'(eq8),  32'd0);
    chk("rst.err8", 32'(err8), 32'd0);
    chk("rst.ov16", 32'(ov16), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.ir8",  32'(ir8),  32'd1);
    chk("rel.ir16", 32'(ir16), 32'd1);

    foreach (tbl[i]) begin
      run8(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("v%0d.lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d.res", i), 32'(res8), 32'(tbl[i].r));
      chk($sformatf("v%0d.flg", i), 32'(flg8), 32'(tbl[i].f));
      chk($sformatf("v%0d.eq", i),  32'(eq8),  32'(tbl[i].eq));
      chk($sformatf("v%0d.err", i), 32'(err8), 32'(tbl[i].er));
    end

    // back-pressure: hold result 3 cycles, ignore new requests
    @(negedge clk);
    ordy8 = 1'b0;
    run8(OP_ADD, 8'd1, 8'd2, lat);
    chk("bp.lat", 32'(lat),  32'd1);
    chk("bp.res", 32'(res8), 32'd3);
    op8 = OP_SUB; a8 = 8'd9; b8 = 8'd1; iv8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.ov", k),  32'(ov8),  32'd1);
      chk($sformatf("bp%0d.res", k), 32'(res8), 32'd3);
      chk($sformatf("bp%0d.flg", k), 32'(flg8), 32'd0);
      chk($sformatf("bp%0d.ir", k),  32'(ir8),  32'd0);
    end
    ordy8 = 1'b1;
    op8 = OP_OR; a8 = 8'h0C; b8 = 8'h03;
    #1;
    chk("bp.ir_rise", 32'(ir8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    chk("bp.ov2",  32'(ov8),  32'd1);
    chk("bp.res2", 32'(res8), 32'h0F);

    // reset in cycle 4 of a MUL
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'd13; b8 = 8'd11; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.ov",  32'(ov8),  32'd0);
    chk("mrst.ir",  32'(ir8),  32'd0);
    chk("mrst.res", 32'(res8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst.ir_rel", 32'(ir8), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    chk("mrst.stale", 32'(seen), 32'd0);
    chk("mrst.res2",  32'(res8), 32'd0);

    run16(OP_ADD, 16'd40000, 16'd30000, lat);
    chk("w16add.lat", 32'(lat),   32'd1);
    chk("w16add.res", 32'(res16), 32'd4464);
    chk("w16add.flg", 32'(flg16), 32'b0010);
    run16(OP_MUL, 16'd300, 16'd300, lat);
    chk("w16mul.lat", 32'(lat),   32'd17);
    chk("w16mul.res", 32'(res16), 32'd24464);
    chk("w16mul.flg", 32'(flg16), 32'b0010);
    run16(OP_MUL, 16'd255, 16'd255, lat);
    chk("w16mul2.res", 32'(res16), 32'hFE01);
    chk("w16mul2.flg", 32'(flg16), 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
